// File: rtl/uart_pkg.sv
// Purpose: shared types and widths for the UART transmit scheduling path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_WORD_W = 9;
  localparam int CFG_SIZE_W  = 4;
  localparam int CFG_PEN_W   = 1;
  localparam int CFG_PTYPE_W = 1;
  localparam int CFG_STOP_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Frame configuration as seen by the transmitter.
  typedef struct packed {
    logic [CFG_SIZE_W-1:0]  data_size;
    logic [CFG_PEN_W-1:0]   parity_en;
    logic [CFG_PTYPE_W-1:0] parity_odd;
    logic [CFG_STOP_W-1:0]  stop_size;
  } uart_cfg_t;

  localparam uart_cfg_t CFG_RESET = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of one requester, searching upward from ptr_i+1 with wrap.
// Latency: purely combinational.
// Backpressure: adv_i=0 suppresses any grant; requests are never stored here.
// Ports: req_i (NREQ requests), ptr_i (last winner), adv_i (grant allowed),
//        gnt_o (one-hot grant), idx_o (encoded winner), vld_o (a grant is issued).
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      idx_o,
  output logic            vld_o
);

  logic [7:0] req_ext;
  logic [3:0] cand;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req_i;
    idx_o              = '0;
    vld_o              = 1'b0;
    cand               = '0;
    // ptr_i < NREQ <= 8, so ptr_i + k never exceeds 15 and a single
    // conditional subtract implements the wrap.
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_i} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (adv_i && !vld_o && req_ext[cand[2:0]]) begin
        vld_o = 1'b1;
        idx_o = cand[2:0];
      end
    end
  end

  assign gnt_o = vld_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// Purpose: shares one UART frame transmitter between NREQ valid/ready requesters, round-robin.
// Latency: grant in the IDLE cycle, tx_start_o one cycle later; gap of GAP_CYCLES+1 after each frame.
// Backpressure: req_ready_o only pulses in IDLE with enable_i and tx_rdy_i high; requesters hold valid until then.
// Ports: clk_i/rst_i (async active-high), enable_i, req_valid_i/req_data_i/req_ready_o,
//        cfg_* frame config inputs, tx_* transmitter interface, busy_o, grant_id_o, err_timeout_o.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ*UART_WORD_W-1:0] req_data_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [CFG_SIZE_W-1:0]       cfg_data_size_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_parity_odd_i,
  input  logic [CFG_STOP_W-1:0]       cfg_stop_size_i,
  output logic                        tx_en_o,
  output logic                        tx_start_o,
  output logic [UART_WORD_W-1:0]      tx_data_o,
  output logic [CFG_SIZE_W-1:0]       tx_data_size_o,
  output logic                        tx_parity_size_o,
  output logic                        tx_parity_type_o,
  output logic [CFG_STOP_W-1:0]       tx_stop_size_o,
  input  logic                        tx_rdy_i,
  output logic                        busy_o,
  output logic [2:0]                  grant_id_o,
  output logic                        err_timeout_o
);

  sched_state_e           state_q, state_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             grant_id_q, grant_id_d;
  logic [UART_WORD_W-1:0] data_q, data_d;
  uart_cfg_t              cfg_q, cfg_d;
  logic [3:0]             tmo_q, tmo_d;
  logic [7:0]             gap_q, gap_d;
  logic                   err_q, err_d;
  logic                   tx_en_q, tx_en_d;

  logic                   arb_adv;
  logic [NREQ-1:0]        arb_gnt;
  logic [2:0]             arb_idx;
  logic                   arb_vld;
  logic [UART_WORD_W-1:0] sel_data;
  uart_cfg_t              cfg_in;

  // rst_i gates the grant so req_ready_o reads as 0 while reset is held.
  assign arb_adv = (state_q == ST_IDLE) && enable_i && tx_rdy_i && !rst_i;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .adv_i (arb_adv),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_data = req_data_i[UART_WORD_W*i +: UART_WORD_W];
    end
  end

  assign cfg_in = {cfg_data_size_i, cfg_parity_en_i, cfg_parity_odd_i, cfg_stop_size_i};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    data_d     = data_q;
    cfg_d      = cfg_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    err_d      = err_q;
    tx_en_d    = enable_i;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          data_d     = sel_data;
          cfg_d      = cfg_in;
          ptr_d      = arb_idx;
          grant_id_d = arb_idx;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tmo_d   = 4'(TIMEOUT);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_rdy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q <= 4'd1) begin
          // Counter reaches zero on this cycle: the transmitter never took the frame.
          tmo_d   = '0;
          err_d   = 1'b1;
          gap_d   = 8'(GAP_CYCLES);
          state_d = ST_GAP;
        end else begin
          tmo_d = tmo_q - 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_rdy_i) begin
          gap_d   = 8'(GAP_CYCLES);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 3'(NREQ-1);
      grant_id_q <= '0;
      data_q     <= '0;
      cfg_q      <= CFG_RESET;
      tmo_q      <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      data_q     <= data_d;
      cfg_q      <= cfg_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign req_ready_o      = arb_gnt;
  assign tx_en_o          = tx_en_q;
  assign tx_start_o       = (state_q == ST_START);
  assign tx_data_o        = data_q;
  assign tx_data_size_o   = cfg_q.data_size;
  assign tx_parity_size_o = cfg_q.parity_en;
  assign tx_parity_type_o = cfg_q.parity_odd;
  assign tx_stop_size_o   = cfg_q.stop_size;
  assign busy_o           = (state_q != ST_IDLE);
  assign grant_id_o       = grant_id_q;
  assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int NREQ = 2;
  localparam int GAP  = 1;
  localparam int TMO  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [1:0]  req_valid_i;
  logic [17:0] req_data_i;
  logic [1:0]  req_ready_o;
  logic [3:0]  cfg_data_size_i;
  logic        cfg_parity_en_i;
  logic        cfg_parity_odd_i;
  logic [1:0]  cfg_stop_size_i;
  logic        tx_en_o;
  logic        tx_start_o;
  logic [8:0]  tx_data_o;
  logic [3:0]  tx_data_size_o;
  logic        tx_parity_size_o;
  logic        tx_parity_type_o;
  logic [1:0]  tx_stop_size_o;
  logic        tx_rdy_i;
  logic        busy_o;
  logic [2:0]  grant_id_o;
  logic        err_timeout_o;

  uart_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .cfg_data_size_i(cfg_data_size_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_parity_odd_i(cfg_parity_odd_i), .cfg_stop_size_i(cfg_stop_size_i),
    .tx_en_o(tx_en_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_data_size_o(tx_data_size_o), .tx_parity_size_o(tx_parity_size_o),
    .tx_parity_type_o(tx_parity_type_o), .tx_stop_size_o(tx_stop_size_o),
    .tx_rdy_i(tx_rdy_i), .busy_o(busy_o), .grant_id_o(grant_id_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Transmitter model: busy for flen_cur cycles after a start, unless stuck.
  int   busy_cnt;
  int   flen_cur;
  logic stuck;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     busy_cnt <= 0;
    else if (tx_start_o && !stuck) busy_cnt <= flen_cur;
    else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
  end
  assign tx_rdy_i = (busy_cnt == 0);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic put_req(input int i, input logic [8:0] d);
    req_valid_i[i]       = 1'b1;
    req_data_i[9*i +: 9] = d;
  endtask

  task automatic wait_ready(input string name);
    for (int c = 0; c < 200; c++) begin
      settle();
      if (|req_ready_o) return;
      tick();
    end
    check(name, 32'(req_ready_o), 32'hFFFF_FFFF);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 300; c++) begin
      settle();
      if (!busy_o) return;
      tick();
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  function automatic logic [7:0] cfg_out();
    return {tx_data_size_o, tx_parity_size_o, tx_parity_type_o, tx_stop_size_o};
  endfunction

  typedef struct {
    int         req;
    logic [8:0] data;
    logic [3:0] size;
    logic       pen;
    logic       podd;
    logic [1:0] stop;
    int         flen;
    logic [1:0] exp_rdy;
    logic [2:0] exp_gid;
  } vec_t;

  typedef struct {
    logic [8:0] data;
    logic [7:0] cfg;
    logic [2:0] gid;
  } exp_t;

  vec_t       vecs[4];
  vec_t       t;
  exp_t       e;
  exp_t       expq[$];
  logic       pend[NREQ];
  logic [8:0] pend_word[NREQ];
  int         mdl_last, exp_i, mdl_j, n, extra_s, extra_r, left;
  int         last_start;
  logic       held, early;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'h0A5, 4'd8, 1'b0, 1'b0, 2'd0, 11, 2'b01, 3'd0};
    vecs[1] = '{1, 9'h122, 4'd9, 1'b1, 1'b1, 2'd2,  5, 2'b10, 3'd1};
    vecs[2] = '{0, 9'h1FF, 4'd6, 1'b1, 1'b0, 2'd1,  1, 2'b01, 3'd0};
    vecs[3] = '{1, 9'h000, 4'd7, 1'b0, 1'b1, 2'd3,  3, 2'b10, 3'd1};

    rst_i = 1'b1; enable_i = 1'b0; req_valid_i = '0; req_data_i = '0;
    cfg_data_size_i = '0; cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0;
    cfg_stop_size_i = '0; stuck = 1'b0; flen_cur = 4;
    settle();
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_start", 32'(tx_start_o), 32'd0);
    check("rst_data",  32'(tx_data_o), 32'd0);
    check("rst_cfg",   32'(cfg_out()), 32'd0);
    check("rst_gid",   32'(grant_id_o), 32'd0);
    check("rst_err",   32'(err_timeout_o), 32'd0);
    check("rst_txen",  32'(tx_en_o), 32'd0);
    tick(); tick();
    rst_i = 1'b0; enable_i = 1'b1;
    tick(); settle();
    check("txen_follows", 32'(tx_en_o), 32'd1);

    // Single-request frames from the vector table.
    for (int v = 0; v < 4; v++) begin
      t = vecs[v];
      tick();
      flen_cur = t.flen;
      cfg_data_size_i = t.size; cfg_parity_en_i = t.pen;
      cfg_parity_odd_i = t.podd; cfg_stop_size_i = t.stop;
      put_req(t.req, t.data);
      wait_ready("vec_ready_timeout");
      check("vec_ready", 32'(req_ready_o), 32'(t.exp_rdy));
      check("vec_idle_at_grant", 32'(busy_o), 32'd0);
      tick();
      req_valid_i = '0;
      settle();
      check("vec_start", 32'(tx_start_o), 32'd1);
      check("vec_data", 32'(tx_data_o), 32'(t.data));
      check("vec_cfg", 32'(cfg_out()), 32'({t.size, t.pen, t.podd, t.stop}));
      check("vec_gid", 32'(grant_id_o), 32'(t.exp_gid));
      cfg_data_size_i = (t.size == 4'd6) ? 4'd9 : 4'd6;
      cfg_parity_en_i = ~t.pen; cfg_parity_odd_i = ~t.podd; cfg_stop_size_i = ~t.stop;
      n = 1; extra_s = 0; extra_r = 0; held = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick(); settle();
        if (!busy_o) break;
        n++;
        if (tx_start_o) extra_s++;
        if (|req_ready_o) extra_r++;
        if (cfg_out() != {t.size, t.pen, t.podd, t.stop}) held = 1'b0;
      end
      check("vec_busy_len", 32'(n), 32'(t.flen + GAP + 3));
      check("vec_single_start", 32'(extra_s), 32'd0);
      check("vec_single_ready", 32'(extra_r), 32'd0);
      check("vec_cfg_held", 32'(held), 32'd1);
    end

    // Contention: both requesters held valid, grants must alternate.
    tick();
    flen_cur = 4;
    put_req(0, 9'h011); put_req(1, 9'h122);
    last_start = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ready("cont_ready_timeout");
      check("cont_ready", 32'(req_ready_o), (g % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_onehot", 32'($countones(req_ready_o)), 32'd1);
      tick(); settle();
      check("cont_start", 32'(tx_start_o), 32'd1);
      check("cont_data", 32'(tx_data_o), (g % 2 == 0) ? 32'h011 : 32'h122);
      check("cont_gid", 32'(grant_id_o), 32'(g % 2));
      if (g > 0) check("cont_spacing", 32'((cyc - last_start) >= 4 + GAP + 2), 32'd1);
      last_start = cyc;
      tick();
    end
    req_valid_i = '0;
    wait_idle("cont_idle_timeout");

    // Timeout: transmitter never leaves ready.
    tick();
    check("tmo_err_clear", 32'(err_timeout_o), 32'd0);
    stuck = 1'b1;
    put_req(0, 9'h055);
    wait_ready("tmo_ready_timeout");
    tick(); req_valid_i = '0; settle();
    check("tmo_start", 32'(tx_start_o), 32'd1);
    early = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      tick(); settle();
      if (err_timeout_o) early = 1'b1;
    end
    check("tmo_not_early", 32'(early), 32'd0);
    tick(); settle();
    check("tmo_err_set", 32'(err_timeout_o), 32'd1);
    check("tmo_in_gap", 32'(busy_o), 32'd1);
    wait_idle("tmo_idle_timeout");
    tick();
    stuck = 1'b0;
    put_req(1, 9'h0CC);
    wait_ready("tmo_next_timeout");
    check("tmo_next_ready", 32'(req_ready_o), 32'd2);
    tick(); req_valid_i = '0; settle();
    check("tmo_next_data", 32'(tx_data_o), 32'h0CC);
    wait_idle("tmo_idle2_timeout");
    check("tmo_sticky", 32'(err_timeout_o), 32'd1);

    // Enable drop mid-frame with req1 pending.
    tick();
    flen_cur = 6;
    put_req(0, 9'h033);
    wait_ready("en_ready0_timeout");
    check("en_ready0", 32'(req_ready_o), 32'd1);
    tick(); req_valid_i = '0;
    tick(); tick();
    enable_i = 1'b0;
    put_req(1, 9'h144);
    extra_r = 0; extra_s = 0;
    for (int c = 0; c < 30; c++) begin
      tick(); settle();
      if (|req_ready_o) extra_r++;
      if (tx_start_o) extra_s++;
    end
    check("en_no_ready", 32'(extra_r), 32'd0);
    check("en_no_start", 32'(extra_s), 32'd0);
    check("en_frame_done", 32'(busy_o), 32'd0);
    check("en_txen_low", 32'(tx_en_o), 32'd0);
    enable_i = 1'b1;
    settle();
    check("en_regrant", 32'(req_ready_o), 32'd2);
    tick(); req_valid_i = '0; settle();
    check("en_start", 32'(tx_start_o), 32'd1);
    check("en_data", 32'(tx_data_o), 32'h144);
    check("en_gid", 32'(grant_id_o), 32'd1);
    check("en_txen_high", 32'(tx_en_o), 32'd1);
    wait_idle("en_idle_timeout");

    // Reset in the middle of a frame.
    tick();
    flen_cur = 10;
    put_req(0, 9'h0AA);
    wait_ready("rst_ready_timeout");
    tick(); req_valid_i = '0;
    tick(); tick(); settle();
    check("rstm_busy_before", 32'(busy_o), 32'd1);
    tick();
    put_req(0, 9'h0AA); put_req(1, 9'h155);
    rst_i = 1'b1;
    settle();
    check("rstm_busy", 32'(busy_o), 32'd0);
    check("rstm_ready", 32'(req_ready_o), 32'd0);
    check("rstm_start", 32'(tx_start_o), 32'd0);
    check("rstm_data", 32'(tx_data_o), 32'd0);
    check("rstm_cfg", 32'(cfg_out()), 32'd0);
    check("rstm_gid", 32'(grant_id_o), 32'd0);
    check("rstm_err", 32'(err_timeout_o), 32'd0);
    check("rstm_txen", 32'(tx_en_o), 32'd0);
    tick();
    rst_i = 1'b0;
    settle();
    check("rstm_first_ready", 32'(req_ready_o), 32'd1);
    tick(); req_valid_i[0] = 1'b0; settle();
    check("rstm_start_after", 32'(tx_start_o), 32'd1);
    check("rstm_data_after", 32'(tx_data_o), 32'h0AA);
    wait_ready("rstm_second_timeout");
    check("rstm_second_ready", 32'(req_ready_o), 32'd2);
    tick(); req_valid_i = '0;
    wait_idle("rstm_idle_timeout");

    // Randomized traffic against a rotating-priority reference model.
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mdl_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (c < 700) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i]      = 1'b1;
            pend_word[i] = 9'($urandom);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid_i[i]       = pend[i];
        req_data_i[9*i +: 9] = pend[i] ? pend_word[i] : 9'($urandom);
      end
      cfg_data_size_i  = 4'($urandom_range(6, 9));
      cfg_parity_en_i  = 1'($urandom);
      cfg_parity_odd_i = 1'($urandom);
      cfg_stop_size_i  = 2'($urandom);
      flen_cur         = int'($urandom_range(1, 6));
      settle();
      if (|req_ready_o) begin
        exp_i = -1;
        for (int k = 1; k <= NREQ; k++) begin
          mdl_j = (mdl_last + k) % NREQ;
          if (exp_i < 0 && pend[mdl_j]) exp_i = mdl_j;
        end
        check("rnd_ready", 32'(req_ready_o), (exp_i >= 0) ? (32'd1 << exp_i) : 32'd0);
        if (exp_i >= 0) begin
          e.data = pend_word[exp_i];
          e.cfg  = {cfg_data_size_i, cfg_parity_en_i, cfg_parity_odd_i, cfg_stop_size_i};
          e.gid  = 3'(exp_i);
          expq.push_back(e);
          pend[exp_i] = 1'b0;
          mdl_last    = exp_i;
        end
      end
      if (tx_start_o) begin
        check("rnd_start_has_grant", 32'(expq.size()), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("rnd_data", 32'(tx_data_o), 32'(e.data));
          check("rnd_cfg", 32'(cfg_out()), 32'(e.cfg));
          check("rnd_gid", 32'(grant_id_o), 32'(e.gid));
        end
      end
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) if (pend[i]) left++;
    check("rnd_all_served", 32'(left), 32'd0);
    check("rnd_no_err", 32'(err_timeout_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART frame transmitter between NREQ requesters.
- Each requester offers a 9-bit word over a valid/ready handshake.
- The scheduler grants one requester and latches the word plus the frame configuration. It then issues a one-cycle start to the transmitter, tracks the frame to completion through the transmitter's ready flag, and inserts a programmable inter-frame gap.
- It sits between the peripheral-side producers and the transmitter in the UART subsystem.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GAP_CYCLES, 1, idle cycles enforced after each frame before the next grant (0..255).
- TIMEOUT, 4, max cycles to wait for the transmitter to leave ready after start before flagging an error (1..15).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  global enable; 0 blocks new grants, an in-flight frame completes.
- req_valid_i  in  NREQ  per-requester word valid.
- req_data_i  in  NREQ*9  per-requester word; slice i = bits [9i+8:9i].
- req_ready_o  out  NREQ  one-hot accept pulse.
- cfg_data_size_i  in  4  data bits, 6..9.
- cfg_parity_en_i  in  1  parity enable.
- cfg_parity_odd_i  in  1  parity type.
- cfg_stop_size_i  in  2  stop bits.
- tx_en_o  out  1  transmitter enable.
- tx_start_o  out  1  transmitter start pulse.
- tx_data_o  out  9  latched word.
- tx_data_size_o  out  4  latched config.
- tx_parity_size_o  out  1  latched config.
- tx_parity_type_o  out  1  latched config.
- tx_stop_size_o  out  2  latched config.
- tx_rdy_i  in  1  transmitter idle/ready.
- busy_o  out  1  a frame is in flight or in its gap.
- grant_id_o  out  3  index of the last granted requester.
- err_timeout_o  out  1  sticky; cleared by reset only.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready_o = 0, tx_start_o = 0, busy_o = 0, err_timeout_o = 0, grant_id_o = 0.
  - tx_data_o = 0; all tx_* config outputs = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
- tx_en_o = enable_i, registered; reset value 0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Grant condition: enable_i=1, tx_rdy_i=1, any valid set.
  - Pick the first valid index searching from pointer+1 upward with wrap at NREQ.
  - req_ready_o[i] is combinational, high only in this cycle.
  - On the clock edge: latch req_data_i slice i and all cfg_* inputs, set pointer and grant_id_o to i, go to START.
- START:
  - tx_start_o=1 for exactly this cycle; tx_data_o and config are already stable.
  - Go to WAIT_BUSY and load the timeout counter with TIMEOUT.
- WAIT_BUSY:
  - tx_rdy_i=0 → WAIT_DONE.
  - Otherwise decrement the counter; at 0, set err_timeout_o and go to GAP.
- WAIT_DONE: remain until tx_rdy_i=1 → GAP, loading the gap counter with GAP_CYCLES.
- GAP: decrement the gap counter; exit to IDLE when it is 0. GAP_CYCLES=0 gives a single GAP cycle.
- busy_o = 1 in every state except IDLE.
- Latched data and config hold from grant until the next grant. Changes to cfg_* mid-frame have no effect.
- Requester data is accepted on the grant cycle only. The requester must hold valid/data until ready; a dropped valid before grant means no transfer.
- Valid asserted simultaneously from several requesters: exactly one ready per grant. With all valid held, the grant order is strictly rotating.
- enable_i falling mid-frame: the frame and gap complete, then no further grants.
- rst_i mid-frame: immediate return to reset values. The transmitter is reset by its own reset.
- Arithmetic:
  - Counters are 4 bits (timeout) and 8 bits (gap), with no wrap.
  - The pointer increments modulo NREQ.

Decomposition:
- Shared package uart_pkg holds:
  - The state encoding.
  - UART_WORD_W=9.
  - The cfg field widths (4/1/1/2).
  - A packed cfg struct reused by the transmitter-side config logic.
- One sub-module: rr_arbiter. It takes NREQ-wide requests and pointer/advance inputs and returns a one-hot grant and an encoded index, combinationally.

Test Plan:
- Single request: req0 valid with 0x0A5, cfg 8 data bits / no parity / 1 stop; transmitter model busy 11 cycles → ready0 pulses once, tx_start_o high 1 cycle the cycle after grant, tx_data_o=0x0A5, busy_o high until GAP ends, then IDLE.
- Contention: req0 and req1 valid continuously with 0x011 and 0x122 → grant order 0,1,0,1; grant_id_o alternates; no two starts closer than frame+GAP_CYCLES+2 cycles.
- Timeout: transmitter model keeps tx_rdy_i=1 after start → err_timeout_o sets after exactly TIMEOUT=4 WAIT_BUSY cycles, stays set, and the scheduler returns to IDLE and serves the next request.
- Config change mid-frame: change cfg_data_size_i 8→6 during WAIT_DONE → tx_data_size_o stays 8 until the next grant, then reads 6.
- Enable drop: deassert enable_i during WAIT_DONE with req1 pending → frame completes, no further ready or start; re-assert → req1 granted next cycle in IDLE.
- Reset mid-frame: assert rst_i in WAIT_DONE → all outputs at reset values same cycle; after release with req0 and req1 both valid, req0 is granted first.
